// File: rtl/fetch_ctrl.sv
// Front-end sequencing controller: PC hold/redirect, F/D and D/E stall/flush,
// I-cache refill handshake and saturating performance counters.
module fetch_ctrl #(
    parameter int BOOT_HOLD = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_d,
    input  logic [4:0]       rs2_d,
    input  logic [4:0]       rd_e,
    input  logic             load_e,
    input  logic             pcsrc_e,
    input  logic             ic_hit,
    input  logic             refill_ack,
    output logic             refill_req,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_d,
    output logic             flush_e,
    output logic [CNT_W-1:0] miss_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] BOOT = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] MISS = 2'd2;

    localparam int             BW          = (BOOT_HOLD > 1) ? $clog2(BOOT_HOLD) : 1;
    localparam logic [BW-1:0]  BOOT_LAST   = BW'((BOOT_HOLD > 0) ? BOOT_HOLD - 1 : 0);
    // With no boot hold the controller leaves reset straight into RUN.
    localparam logic [1:0]     RESET_STATE = (BOOT_HOLD == 0) ? RUN : BOOT;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [BW-1:0] boot_cnt;
    logic          hazard;
    logic          miss_enter;

    assign hazard = load_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        miss_enter = 1'b0;
        state_nxt  = state;
        if (rst) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else begin
            case (state)
                BOOT: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                    if (boot_cnt == BOOT_LAST) state_nxt = RUN;
                end
                RUN: begin
                    // A redirect squashes whatever fetch/decode were doing,
                    // so a concurrent miss or hazard is moot.
                    if (pcsrc_e) begin
                        flush_d = 1'b1;
                        flush_e = 1'b1;
                    end else if (!ic_hit) begin
                        stall_f    = 1'b1;
                        stall_d    = 1'b1;
                        flush_e    = 1'b1;
                        miss_enter = 1'b1;
                        state_nxt  = MISS;
                    end else if (hazard) begin
                        stall_f = 1'b1;
                        stall_d = 1'b1;
                        flush_e = 1'b1;
                    end
                end
                MISS: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                    if (refill_ack) state_nxt = RUN;
                end
                default: state_nxt = RESET_STATE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RESET_STATE;
            boot_cnt   <= '0;
            refill_req <= 1'b0;
            miss_cnt   <= '0;
            stall_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == BOOT) boot_cnt <= boot_cnt + BW'(1);

            if (miss_enter)
                refill_req <= 1'b1;
            else if (state == MISS && refill_ack)
                refill_req <= 1'b0;

            if (miss_enter && miss_cnt != '1)
                miss_cnt <= miss_cnt + CNT_W'(1);

            if (stall_f && (state == RUN || state == MISS) && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
